store_buffer: RTL and testbench

Write-back buffer between the store unit and the store memory controller. Committed stores are queued in a small in-order FIFO and drained to the controller one at a time, which frees the store unit from waiting on memory. Every cycle the buffer searches its valid entries for the address presented by the load unit. On a clean hit it forwards the buffered word, so a load never reads stale memory behind a pending store.

---
 rtl/load_store_unit_pkg.sv | 16 +
 rtl/store_buffer.sv | 108 ++++++++++
 tb/tb_store_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: store widths and the buffered store entry.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        STB = 2'd0,
        STH = 2'd1,
        STW = 2'd2
    } store_width_t;

    typedef struct packed {
        logic [31:0]  address;
        logic [31:0]  data;
        store_width_t width;
    } store_buffer_entry_t;

endpackage

// File: rtl/store_buffer.sv
// In-order write-back store buffer: queues committed stores, drains them one at a
// time to the store memory controller, and forwards the youngest matching word to loads.
module store_buffer
    import load_store_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [31:0]  push_address_i,
    input  logic [31:0]  push_data_i,
    input  store_width_t push_width_i,
    output logic         full_o,
    output logic         empty_o,
    output logic         st_ctrl_request_o,
    output logic [31:0]  st_ctrl_address_o,
    output logic [31:0]  st_ctrl_data_o,
    output store_width_t st_ctrl_width_o,
    input  logic         st_ctrl_done_i,
    input  logic [31:0]  fwd_address_i,
    output logic         fwd_match_o,
    output logic [31:0]  fwd_data_o,
    output logic         fwd_conflict_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    store_buffer_entry_t entries [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;

    logic                push_ok;
    logic                pop;
    logic [PTR_W:0]      hit;
    store_buffer_entry_t hit_entry;
    logic                unused_fwd_offset;

    assign full_o  = (count == (PTR_W+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign push_ok = push_i && !full_o;
    assign pop     = (state == WAIT) && st_ctrl_done_i;

    // Request is a one-cycle pulse because IDLE always moves to WAIT when non-empty.
    assign st_ctrl_request_o = (state == IDLE) && !empty_o;
    assign st_ctrl_address_o = entries[head].address;
    assign st_ctrl_data_o    = entries[head].data;
    assign st_ctrl_width_o   = entries[head].width;

    // Valid entries are contiguous from head to tail-1, so the first hit walking
    // backward from tail-1 is the youngest store to that word.
    function automatic logic [PTR_W:0] youngest_match(input logic [29:0] word);
        logic [PTR_W:0]   result;
        logic [PTR_W-1:0] idx;
        result = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            idx = tail - PTR_W'(i);
            if (!result[PTR_W] && valid[idx] && (entries[idx].address[31:2] == word))
                result = {1'b1, idx};
        end
        return result;
    endfunction

    assign unused_fwd_offset = ^fwd_address_i[1:0];
    assign hit               = youngest_match(fwd_address_i[31:2]);
    assign hit_entry         = entries[hit[PTR_W-1:0]];
    assign fwd_match_o       = hit[PTR_W] && (hit_entry.width == STW);
    assign fwd_conflict_o    = hit[PTR_W] && (hit_entry.width != STW);
    assign fwd_data_o        = fwd_match_o ? hit_entry.data : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else begin
            if (push_ok) begin
                entries[tail] <= '{address: push_address_i, data: push_data_i, width: push_width_i};
                valid[tail]   <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            case (state)
                IDLE:    if (!empty_o) state <= WAIT;
                WAIT:    if (st_ctrl_done_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_store_buffer;
    import load_store_unit_pkg::*;

    localparam int DEPTH = 4;

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         push_i = 1'b0;
    logic [31:0]  push_address_i = '0;
    logic [31:0]  push_data_i = '0;
    store_width_t push_width_i = STW;
    logic         full_o, empty_o, st_ctrl_request_o;
    logic [31:0]  st_ctrl_address_o, st_ctrl_data_o;
    store_width_t st_ctrl_width_o;
    logic         st_ctrl_done_i = 1'b0;
    logic [31:0]  fwd_address_i = '0;
    logic         fwd_match_o, fwd_conflict_o;
    logic [31:0]  fwd_data_o;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .push_i(push_i), .push_address_i(push_address_i), .push_data_i(push_data_i),
        .push_width_i(push_width_i), .full_o(full_o), .empty_o(empty_o),
        .st_ctrl_request_o(st_ctrl_request_o), .st_ctrl_address_o(st_ctrl_address_o),
        .st_ctrl_data_o(st_ctrl_data_o), .st_ctrl_width_o(st_ctrl_width_o),
        .st_ctrl_done_i(st_ctrl_done_i), .fwd_address_i(fwd_address_i),
        .fwd_match_o(fwd_match_o), .fwd_data_o(fwd_data_o), .fwd_conflict_o(fwd_conflict_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending stores and whether a write is outstanding.
    store_buffer_entry_t q[$];
    bit                  waiting;
    bit                  was_full;
    logic [31:0]         req_log[$];
    int                  hit;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q.delete();
            waiting = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (waiting && st_ctrl_done_i) begin
                void'(q.pop_front());
                waiting = 0;
            end else if (!waiting && q.size() > 0) begin
                waiting = 1;
            end
            if (push_i && !was_full)
                q.push_back('{address: push_address_i, data: push_data_i, width: push_width_i});
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            chk("empty", empty_o, (q.size() == 0));
            chk("full", full_o, (q.size() == DEPTH));
            chk("request", st_ctrl_request_o, (!waiting && q.size() > 0));
            if (q.size() > 0) begin
                chk("st_addr", st_ctrl_address_o, q[0].address);
                chk("st_data", st_ctrl_data_o, q[0].data);
                chk("st_width", st_ctrl_width_o, q[0].width);
            end
            hit = -1;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].address[31:2] == fwd_address_i[31:2]) begin
                    hit = i;
                    break;
                end
            end
            chk("fwd_match", fwd_match_o, (hit >= 0 && q[hit].width == STW));
            chk("fwd_conflict", fwd_conflict_o, (hit >= 0 && q[hit].width != STW));
            if (hit < 0)
                chk("fwd_data_none", fwd_data_o, 32'h0);
            else if (q[hit].width == STW)
                chk("fwd_data", fwd_data_o, q[hit].data);
            if (st_ctrl_request_o)
                req_log.push_back(st_ctrl_address_o);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input store_width_t w);
        push_i = 1'b1;
        push_address_i = a;
        push_data_i = d;
        push_width_i = w;
        cyc();
        push_i = 1'b0;
    endtask

    task automatic drain_all();
        st_ctrl_done_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (empty_o) break;
            cyc();
        end
        chk("drain_timeout", empty_o, 1'b1);
        st_ctrl_done_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_full"}, full_o, 1'b0);
        chk({tag, "_empty"}, empty_o, 1'b1);
        chk({tag, "_request"}, st_ctrl_request_o, 1'b0);
        chk({tag, "_st_addr"}, st_ctrl_address_o, 32'h0);
        chk({tag, "_st_data"}, st_ctrl_data_o, 32'h0);
        chk({tag, "_st_width"}, st_ctrl_width_o, 32'h0);
        chk({tag, "_fwd_match"}, fwd_match_o, 1'b0);
        chk({tag, "_fwd_conflict"}, fwd_conflict_o, 1'b0);
        chk({tag, "_fwd_data"}, fwd_data_o, 32'h0);
    endtask

    initial begin
        #1;
        chk_reset_outputs("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        cyc();

        // Single store: request one cycle after the push edge, pop after done.
        push(32'h0000_1000, 32'hDEAD_BEEF, STW);
        chk("t1_request", st_ctrl_request_o, 1'b1);
        chk("t1_addr", st_ctrl_address_o, 32'h0000_1000);
        chk("t1_data", st_ctrl_data_o, 32'hDEAD_BEEF);
        chk("t1_width", st_ctrl_width_o, STW);
        cyc();
        chk("t1_request_pulse", st_ctrl_request_o, 1'b0);
        cyc();
        st_ctrl_done_i = 1'b1;
        cyc();
        st_ctrl_done_i = 1'b0;
        chk("t1_empty_after_done", empty_o, 1'b1);

        // Fill with controller stalled, drop a fifth push, drain in order.
        cyc();
        req_log.delete();
        for (int i = 0; i < 4; i++)
            push(32'h0000_5000 + 32'(i) * 32'h10, 32'(i), STW);
        chk("t2_full", full_o, 1'b1);
        push(32'h0000_5100, 32'h5555_5555, STW);
        chk("t2_full_after_drop", full_o, 1'b1);
        drain_all();
        for (int n = 0; n < 4; n++) cyc();
        chk("t2_request_count", req_log.size(), 4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk("t2_request_order", req_log[i], 32'h0000_5000 + 32'(i) * 32'h10);

        // Youngest matching store wins.
        push(32'h0000_2000, 32'h1111_1111, STW);
        push(32'h0000_2000, 32'h2222_2222, STW);
        fwd_address_i = 32'h0000_2002;
        #1;
        chk("t3_match", fwd_match_o, 1'b1);
        chk("t3_data", fwd_data_o, 32'h2222_2222);
        chk("t3_conflict", fwd_conflict_o, 1'b0);
        drain_all();

        // Partial-width youngest store forces a conflict.
        push(32'h0000_3000, 32'h3333_3333, STW);
        push(32'h0000_3001, 32'h0000_5500, STB);
        fwd_address_i = 32'h0000_3000;
        #1;
        chk("t4_conflict", fwd_conflict_o, 1'b1);
        chk("t4_match", fwd_match_o, 1'b0);
        fwd_address_i = 32'h0000_3004;
        #1;
        chk("t4_miss_match", fwd_match_o, 1'b0);
        chk("t4_miss_conflict", fwd_conflict_o, 1'b0);
        chk("t4_miss_data", fwd_data_o, 32'h0);
        drain_all();

        // Head in WAIT still forwards; push and pop together keep count.
        push(32'h0000_4000, 32'h4444_4444, STW);
        fwd_address_i = 32'h0000_4000;
        cyc();
        chk("t5_wait_match", fwd_match_o, 1'b1);
        chk("t5_wait_data", fwd_data_o, 32'h4444_4444);
        st_ctrl_done_i = 1'b1;
        push(32'h0000_4100, 32'h4141_4141, STW);
        st_ctrl_done_i = 1'b0;
        chk("t5_popped_match", fwd_match_o, 1'b0);
        chk("t5_count_kept", empty_o, 1'b0);
        chk("t5_next_request", st_ctrl_request_o, 1'b1);
        chk("t5_next_addr", st_ctrl_address_o, 32'h0000_4100);
        cyc();
        st_ctrl_done_i = 1'b1;
        cyc();
        st_ctrl_done_i = 1'b0;
        chk("t5_single_entry", empty_o, 1'b1);
        fwd_address_i = 32'h0;

        // Asynchronous reset while draining with three entries.
        push(32'h0000_7000, 32'h7000_0000, STW);
        push(32'h0000_7004, 32'h7000_0004, STW);
        push(32'h0000_7008, 32'h7000_0008, STW);
        fwd_address_i = 32'h0000_7004;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_reset_outputs("async");
        cyc();
        rst_n_i = 1'b1;
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            push_i = ($urandom_range(0, 99) < 45);
            push_address_i = 32'h0000_6000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            push_data_i = $urandom;
            push_width_i = store_width_t'($urandom_range(0, 2));
            st_ctrl_done_i = ($urandom_range(0, 99) < 35);
            fwd_address_i = 32'h0000_6000 + 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(0, 3));
            cyc();
        end
        push_i = 1'b0;
        drain_all();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
